// File: rtl/midi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | midi_pkg                                                              |
// | Shared constants for the MIDI message sequencer: FSM encoding,        |
// | MIDI status nibbles and the WAIT_HI busy timeout.                     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package midi_pkg;

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_LOAD    = 3'd1;
    localparam logic [2:0] c_SEND    = 3'd2;
    localparam logic [2:0] c_WAIT_HI = 3'd3;
    localparam logic [2:0] c_WAIT_LO = 3'd4;
    localparam logic [2:0] c_GAP     = 3'd5;

    localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
    localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;

    localparam int c_WAIT_HI_TIMEOUT = 16;

    function automatic logic [7:0] midi_status(input logic on, input logic [3:0] chan);
        return {(on ? MIDI_NOTE_ON : MIDI_NOTE_OFF), chan};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter2                                                           |
// | Two-requester round-robin arbiter; on contention the requester that   |
// | was not granted last wins.                                            |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant_valid,
    output logic       grant_id
);

    assign grant_valid = |req;

    always_comb begin
        grant_id = 1'b0;
        if (req == 2'b11) begin
            grant_id = ~last;
        end else if (req[1]) begin
            grant_id = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/midi_msg_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | midi_msg_sequencer                                                    |
// | Arbitrates two Note On/Off requesters and streams 3-byte MIDI         |
// | messages to a byte UART. Optional: MIDI_RUNNING_STATUS_EN.            |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module midi_msg_sequencer
    import midi_pkg::*;
#(
    parameter int GAP_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [1:0]  req_on,
    input  logic [7:0]  req_chan,
    input  logic [13:0] req_note,
    input  logic [13:0] req_vel,
    output logic [1:0]  ack,
    output logic        tx_send,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic        active,
    output logic        grant_id
);

    localparam int c_GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int c_TOUT_W = $clog2(c_WAIT_HI_TIMEOUT + 1);
    localparam logic [c_TOUT_W-1:0] c_TOUT_LAST = c_TOUT_W'(c_WAIT_HI_TIMEOUT - 1);

    logic [2:0]          state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic                on_q, on_d;
    logic [3:0]          chan_q, chan_d;
    logic [6:0]          note_q, note_d;
    logic [6:0]          vel_q, vel_d;
    logic                tx_send_q, tx_send_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic [1:0]          ack_q, ack_d;
    logic                grant_id_q, grant_id_d;
    logic [c_GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [c_TOUT_W-1:0] tout_cnt_q, tout_cnt_d;
`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0]          last_status_q, last_status_d;
    logic                last_valid_q, last_valid_d;
`endif

    logic       w_grant_valid;
    logic       w_grant_id;
    logic [7:0] w_status;
    logic [7:0] w_byte;
    logic       w_gap_done;

    rr_arbiter2 u_arb (
        .req         (req),
        .last        (grant_id_q),
        .grant_valid (w_grant_valid),
        .grant_id    (w_grant_id)
    );

    assign w_status   = midi_status(on_q, chan_q);
    assign w_gap_done = (GAP_CYCLES == 0) || ((int'(gap_cnt_q) + 1) >= GAP_CYCLES);

    always_comb begin
        case (idx_q)
            2'd0:    w_byte = w_status;
            2'd1:    w_byte = {1'b0, note_q};
            default: w_byte = {1'b0, vel_q};
        endcase
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        on_d       = on_q;
        chan_d     = chan_q;
        note_d     = note_q;
        vel_d      = vel_q;
        tx_send_d  = 1'b0;
        tx_data_d  = tx_data_q;
        ack_d      = 2'b00;
        grant_id_d = grant_id_q;
        gap_cnt_d  = gap_cnt_q;
        tout_cnt_d = tout_cnt_q;
`ifdef MIDI_RUNNING_STATUS_EN
        last_status_d = last_status_q;
        last_valid_d  = last_valid_q;
`endif
        case (state_q)
            c_IDLE: begin
                if (w_grant_valid && !tx_busy) begin
                    state_d    = c_LOAD;
                    ack_d      = w_grant_id ? 2'b10 : 2'b01;
                    grant_id_d = w_grant_id;
                    on_d       = w_grant_id ? req_on[1]       : req_on[0];
                    chan_d     = w_grant_id ? req_chan[7:4]   : req_chan[3:0];
                    note_d     = w_grant_id ? req_note[13:7]  : req_note[6:0];
                    vel_d      = w_grant_id ? req_vel[13:7]   : req_vel[6:0];
                end
            end
            c_LOAD: begin
                idx_d   = 2'd0;
`ifdef MIDI_RUNNING_STATUS_EN
                if (last_valid_q && (last_status_q == w_status)) begin
                    idx_d = 2'd1;
                end
`endif
                state_d = c_SEND;
            end
            c_SEND: begin
                tx_data_d  = w_byte;
                tx_send_d  = 1'b1;
                tout_cnt_d = '0;
                state_d    = c_WAIT_HI;
            end
            c_WAIT_HI: begin
                // A UART that never raises busy must not stall the stream.
                if (tx_busy || (tout_cnt_q >= c_TOUT_LAST)) begin
                    state_d = c_WAIT_LO;
                end else begin
                    tout_cnt_d = tout_cnt_q + 1'b1;
                end
            end
            c_WAIT_LO: begin
                if (!tx_busy) begin
`ifdef MIDI_RUNNING_STATUS_EN
                    if (idx_q == 2'd0) begin
                        last_status_d = w_status;
                        last_valid_d  = 1'b1;
                    end
`endif
                    if (idx_q < 2'd2) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = c_SEND;
                    end else begin
                        gap_cnt_d = '0;
                        state_d   = c_GAP;
                    end
                end
            end
            c_GAP: begin
                if (w_gap_done) begin
                    state_d = c_IDLE;
                end else if (gap_cnt_q != {c_GAP_W{1'b1}}) begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= c_IDLE;
            idx_q      <= 2'd0;
            on_q       <= 1'b0;
            chan_q     <= 4'h0;
            note_q     <= 7'h00;
            vel_q      <= 7'h00;
            tx_send_q  <= 1'b0;
            tx_data_q  <= 8'h00;
            ack_q      <= 2'b00;
            grant_id_q <= 1'b1;
            gap_cnt_q  <= '0;
            tout_cnt_q <= '0;
`ifdef MIDI_RUNNING_STATUS_EN
            last_status_q <= 8'h00;
            last_valid_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            on_q       <= on_d;
            chan_q     <= chan_d;
            note_q     <= note_d;
            vel_q      <= vel_d;
            tx_send_q  <= tx_send_d;
            tx_data_q  <= tx_data_d;
            ack_q      <= ack_d;
            grant_id_q <= grant_id_d;
            gap_cnt_q  <= gap_cnt_d;
            tout_cnt_q <= tout_cnt_d;
`ifdef MIDI_RUNNING_STATUS_EN
            last_status_q <= last_status_d;
            last_valid_q  <= last_valid_d;
`endif
        end
    end

    assign ack      = ack_q;
    assign tx_send  = tx_send_q;
    assign tx_data  = tx_data_q;
    assign active   = (state_q != c_IDLE);
    assign grant_id = grant_id_q;

endmodule
`default_nettype wire
